// File: rtl/kmeans_pkg.sv
// Shared definitions for the centroid tracking slice.
//   state_e   : tracker FSM states (IDLE / WAIT_RESULT)
//   X_W / Y_W : coordinate widths (11-bit x, 10-bit y)
//   D_W       : width of a Manhattan distance (fits 2047 + 1023)
//   point_t   : packed {x, y} coordinate
//   manhattan : |dx| + |dy| between two points, unsigned D_W bits
package kmeans_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;
    localparam int D_W = 12;

    typedef enum logic {
        ST_IDLE        = 1'b0,
        ST_WAIT_RESULT = 1'b1
    } state_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } point_t;

    function automatic logic [D_W-1:0] manhattan(input point_t a, input point_t b);
        logic [X_W-1:0] dx;
        logic [Y_W-1:0] dy;
        dx = (a.x >= b.x) ? (a.x - b.x) : (b.x - a.x);
        dy = (a.y >= b.y) ? (a.y - b.y) : (b.y - a.y);
        return D_W'(dx) + D_W'(dy);
    endfunction

endpackage

// File: rtl/centroid_sort3.sv
// Registered three-point sort by ascending x, one cycle of latency.
// Equal x values keep input order (a before b before c).
// Ports:
//   clk_in, rst_n_in       : clock, asynchronous active-low reset
//   valid_in               : load a new sorted set this cycle
//   a_in, b_in, c_in       : points to sort
//   key_0/1/2_out          : sorted points (key_0 smallest x)
//   valid_out              : one-cycle pulse when the keys refresh
module centroid_sort3 import kmeans_pkg::*; #(
    parameter int SEED_AX = 320,
    parameter int SEED_BX = 640,
    parameter int SEED_CX = 960,
    parameter int SEED_Y  = 360
) (
    input  logic   clk_in,
    input  logic   rst_n_in,
    input  logic   valid_in,
    input  point_t a_in,
    input  point_t b_in,
    input  point_t c_in,
    output point_t key_0_out,
    output point_t key_1_out,
    output point_t key_2_out,
    output logic   valid_out
);

    logic [1:0] rank_a, rank_b, rank_c;
    point_t     sorted [3];

    // Rank = number of points that must precede this one. Strict '<' against
    // later inputs and '<=' against earlier ones makes the ranks unique and
    // keeps ties in input order.
    always_comb begin
        rank_a = 2'(b_in.x <  a_in.x) + 2'(c_in.x <  a_in.x);
        rank_b = 2'(a_in.x <= b_in.x) + 2'(c_in.x <  b_in.x);
        rank_c = 2'(a_in.x <= c_in.x) + 2'(b_in.x <= c_in.x);
        sorted[0] = a_in;
        sorted[1] = b_in;
        sorted[2] = c_in;
        sorted[rank_a] = a_in;
        sorted[rank_b] = b_in;
        sorted[rank_c] = c_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            key_0_out <= {X_W'(SEED_AX), Y_W'(SEED_Y)};
            key_1_out <= {X_W'(SEED_BX), Y_W'(SEED_Y)};
            key_2_out <= {X_W'(SEED_CX), Y_W'(SEED_Y)};
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                key_0_out <= sorted[0];
                key_1_out <= sorted[1];
                key_2_out <= sorted[2];
            end
        end
    end

endmodule

// File: rtl/centroid_tracker.sv
// Tracks three cluster centroids across frames. After each frame it asks the
// clustering stage for new means (tabulate_out), waits for the result with a
// timeout, loads in-range means, measures per-cluster movement for
// convergence detection, and publishes the centroids sorted by x.
// Handshake: frame_done_in and km_valid_in are single-cycle pulses with no
// back-pressure; a pulse that arrives in a state that cannot use it is dropped.
// Ports:
//   clk_in, rst_n_in              : clock, asynchronous active-low reset
//   frame_done_in                 : end-of-frame pulse
//   km_valid_in, km_*_x/y_in      : clustering result pulse and means
//   centroid_*_x/y_out            : current centroids (fed back to clustering)
//   tabulate_out                  : one-cycle request for new means
//   key_0/1/2_x/y_out             : centroids sorted by ascending x
//   update_valid_out              : pulse when the key outputs refresh
//   converged_out                 : centroids stable for CONV_FRAMES updates
//   timeout_out                   : sticky, a result wait expired
//   state_out                     : current FSM state (debug)
module centroid_tracker import kmeans_pkg::*; #(
    parameter int H_ACTIVE       = 1280,
    parameter int V_ACTIVE       = 720,
    parameter int SEED_AX        = 320,
    parameter int SEED_BX        = 640,
    parameter int SEED_CX        = 960,
    parameter int SEED_Y         = 360,
    parameter int CONV_THRESH    = 4,
    parameter int CONV_FRAMES    = 3,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           frame_done_in,
    input  logic           km_valid_in,
    input  logic [X_W-1:0] km_a_x_in,
    input  logic [X_W-1:0] km_b_x_in,
    input  logic [X_W-1:0] km_c_x_in,
    input  logic [Y_W-1:0] km_a_y_in,
    input  logic [Y_W-1:0] km_b_y_in,
    input  logic [Y_W-1:0] km_c_y_in,
    output logic [X_W-1:0] centroid_a_x_out,
    output logic [X_W-1:0] centroid_b_x_out,
    output logic [X_W-1:0] centroid_c_x_out,
    output logic [Y_W-1:0] centroid_a_y_out,
    output logic [Y_W-1:0] centroid_b_y_out,
    output logic [Y_W-1:0] centroid_c_y_out,
    output logic           tabulate_out,
    output logic [X_W-1:0] key_0_x_out,
    output logic [X_W-1:0] key_1_x_out,
    output logic [X_W-1:0] key_2_x_out,
    output logic [Y_W-1:0] key_0_y_out,
    output logic [Y_W-1:0] key_1_y_out,
    output logic [Y_W-1:0] key_2_y_out,
    output logic           update_valid_out,
    output logic           converged_out,
    output logic           timeout_out,
    output state_e         state_out
);

    localparam int WC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SC_W = $clog2(CONV_FRAMES + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SC_W-1:0] STILL_MAX = SC_W'(CONV_FRAMES);
    localparam logic [X_W:0]    H_LIM     = (X_W + 1)'(H_ACTIVE);
    localparam logic [Y_W:0]    V_LIM     = (Y_W + 1)'(V_ACTIVE);
    localparam logic [D_W-1:0]  THRESH    = D_W'(CONV_THRESH);

    state_e          state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q;
    logic [SC_W-1:0] still_cnt_q;
    logic            timeout_q, converged_q, upd_q;
    logic            accept, expire, still;
    point_t          cent_q   [3];
    point_t          km_pt    [3];
    logic            in_range [3];
    logic [D_W-1:0]  move     [3];
    point_t          key_0, key_1, key_2;

    assign km_pt[0] = {km_a_x_in, km_a_y_in};
    assign km_pt[1] = {km_b_x_in, km_b_y_in};
    assign km_pt[2] = {km_c_x_in, km_c_y_in};

    assign accept = (state_q == ST_WAIT_RESULT) && km_valid_in;
    assign expire = (state_q == ST_WAIT_RESULT) && !km_valid_in && (wait_cnt_q == WAIT_LAST);

    // FSM: state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (frame_done_in)     state_d = ST_WAIT_RESULT;
            ST_WAIT_RESULT: if (accept || expire)  state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        tabulate_out = (state_q == ST_IDLE) && frame_done_in;
    end

    // Out-of-range means (e.g. an empty cluster's divide-by-zero) keep the
    // old centroid and count as no movement.
    always_comb begin
        still = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_range[i] = ({1'b0, km_pt[i].x} < H_LIM) && ({1'b0, km_pt[i].y} < V_LIM);
            move[i]     = in_range[i] ? manhattan(cent_q[i], km_pt[i]) : '0;
            if (move[i] > THRESH) still = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            still_cnt_q <= '0;
            upd_q       <= 1'b0;
            converged_q <= 1'b0;
            cent_q[0]   <= {X_W'(SEED_AX), Y_W'(SEED_Y)};
            cent_q[1]   <= {X_W'(SEED_BX), Y_W'(SEED_Y)};
            cent_q[2]   <= {X_W'(SEED_CX), Y_W'(SEED_Y)};
        end else begin
            // Held at zero while idle so every wait starts from a clean count.
            if (state_q == ST_IDLE) wait_cnt_q <= '0;
            else                    wait_cnt_q <= wait_cnt_q + 1'b1;
            timeout_q <= timeout_q | expire;
            upd_q     <= accept;
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    if (in_range[i]) cent_q[i] <= km_pt[i];
                end
                if (!still)                        still_cnt_q <= '0;
                else if (still_cnt_q != STILL_MAX) still_cnt_q <= still_cnt_q + 1'b1;
            end
            // Aligned with the sorted keys, one cycle after the centroids.
            if (upd_q) converged_q <= (still_cnt_q == STILL_MAX);
        end
    end

    centroid_sort3 #(
        .SEED_AX (SEED_AX),
        .SEED_BX (SEED_BX),
        .SEED_CX (SEED_CX),
        .SEED_Y  (SEED_Y)
    ) u_sort (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .valid_in  (upd_q),
        .a_in      (cent_q[0]),
        .b_in      (cent_q[1]),
        .c_in      (cent_q[2]),
        .key_0_out (key_0),
        .key_1_out (key_1),
        .key_2_out (key_2),
        .valid_out (update_valid_out)
    );

    assign centroid_a_x_out = cent_q[0].x;
    assign centroid_a_y_out = cent_q[0].y;
    assign centroid_b_x_out = cent_q[1].x;
    assign centroid_b_y_out = cent_q[1].y;
    assign centroid_c_x_out = cent_q[2].x;
    assign centroid_c_y_out = cent_q[2].y;
    assign key_0_x_out      = key_0.x;
    assign key_0_y_out      = key_0.y;
    assign key_1_x_out      = key_1.x;
    assign key_1_y_out      = key_1.y;
    assign key_2_x_out      = key_2.x;
    assign key_2_y_out      = key_2.y;
    assign converged_out    = converged_q;
    assign timeout_out      = timeout_q;
    assign state_out        = state_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Bench for centroid_tracker: directed results with hand-computed centroids,
// sorted keys and convergence; a monitor checks every update_valid_out
// against the expected queue.
module tb_centroid_tracker;
    import kmeans_pkg::*;

    localparam int EW = 64;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic           frame_done_in;
    logic           km_valid_in;
    logic [10:0]    km_a_x_in, km_b_x_in, km_c_x_in;
    logic [9:0]     km_a_y_in, km_b_y_in, km_c_y_in;
    logic [10:0]    centroid_a_x_out, centroid_b_x_out, centroid_c_x_out;
    logic [9:0]     centroid_a_y_out, centroid_b_y_out, centroid_c_y_out;
    logic           tabulate_out;
    logic [10:0]    key_0_x_out, key_1_x_out, key_2_x_out;
    logic [9:0]     key_0_y_out, key_1_y_out, key_2_y_out;
    logic           update_valid_out, converged_out, timeout_out;
    state_e         state_out;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [EW-1:0]  exp_q[$];

    wire logic [62:0] cent_now = {centroid_a_x_out, centroid_a_y_out, centroid_b_x_out,
                                  centroid_b_y_out, centroid_c_x_out, centroid_c_y_out};
    wire logic [62:0] key_now  = {key_0_x_out, key_0_y_out, key_1_x_out,
                                  key_1_y_out, key_2_x_out, key_2_y_out};

    centroid_tracker #(.TIMEOUT_CYCLES(16)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .frame_done_in    (frame_done_in),
        .km_valid_in      (km_valid_in),
        .km_a_x_in        (km_a_x_in),
        .km_b_x_in        (km_b_x_in),
        .km_c_x_in        (km_c_x_in),
        .km_a_y_in        (km_a_y_in),
        .km_b_y_in        (km_b_y_in),
        .km_c_y_in        (km_c_y_in),
        .centroid_a_x_out (centroid_a_x_out),
        .centroid_b_x_out (centroid_b_x_out),
        .centroid_c_x_out (centroid_c_x_out),
        .centroid_a_y_out (centroid_a_y_out),
        .centroid_b_y_out (centroid_b_y_out),
        .centroid_c_y_out (centroid_c_y_out),
        .tabulate_out     (tabulate_out),
        .key_0_x_out      (key_0_x_out),
        .key_1_x_out      (key_1_x_out),
        .key_2_x_out      (key_2_x_out),
        .key_0_y_out      (key_0_y_out),
        .key_1_y_out      (key_1_y_out),
        .key_2_y_out      (key_2_y_out),
        .update_valid_out (update_valid_out),
        .converged_out    (converged_out),
        .timeout_out      (timeout_out),
        .state_out        (state_out)
    );

    // Clock / reset
    always #5 clk_in = ~clk_in;

    function automatic logic [62:0] pk(input int ax, input int ay, input int bx,
                                       input int by, input int cx, input int cy);
        return {11'(ax), 10'(ay), 11'(bx), 10'(by), 11'(cx), 10'(cy)};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk_in) begin
        if (update_valid_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_update: actual keys=%h required no update", key_now);
            end else begin
                check("update_keys_conv", {key_now, converged_out}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic do_frame();
        @(posedge clk_in); #1 frame_done_in = 1'b1;
        @(negedge clk_in); check("tabulate_pulse", 64'(tabulate_out), 64'd1);
        @(posedge clk_in); #1 frame_done_in = 1'b0;
        @(negedge clk_in); check("tabulate_single", 64'(tabulate_out), 64'd0);
    endtask

    task automatic send_result(input logic [62:0] km, input logic [62:0] exp_cent,
                               input logic [62:0] exp_keys, input logic exp_conv,
                               input logic fd_same);
        do_frame();
        exp_q.push_back({exp_keys, exp_conv});
        @(posedge clk_in); #1;
        {km_a_x_in, km_a_y_in, km_b_x_in, km_b_y_in, km_c_x_in, km_c_y_in} = km;
        km_valid_in   = 1'b1;
        frame_done_in = fd_same;
        @(negedge clk_in); check("no_tabulate_in_wait", 64'(tabulate_out), 64'd0);
        @(posedge clk_in); #1 km_valid_in = 1'b0; frame_done_in = 1'b0;
        @(negedge clk_in); check("centroids_n1", 64'(cent_now), 64'(exp_cent));
        @(negedge clk_in); check("update_valid_n2", 64'(update_valid_out), 64'd1);
        @(negedge clk_in); check("update_valid_single", 64'(update_valid_out), 64'd0);
    endtask

    initial begin
        int n;
        rst_n_in = 1'b0; frame_done_in = 1'b0; km_valid_in = 1'b0;
        {km_a_x_in, km_a_y_in, km_b_x_in, km_b_y_in, km_c_x_in, km_c_y_in} = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_centroids", 64'(cent_now), 64'(pk(320, 360, 640, 360, 960, 360)));
        check("rst_keys", 64'(key_now), 64'(pk(320, 360, 640, 360, 960, 360)));
        check("rst_flags", 64'({tabulate_out, update_valid_out, converged_out, timeout_out}), 64'd0);
        rst_n_in = 1'b1;

        // First result: large moves, keys sorted by x
        send_result(pk(100, 50, 900, 600, 500, 300), pk(100, 50, 900, 600, 500, 300),
                    pk(100, 50, 500, 300, 900, 600), 1'b0, 1'b0);
        // Four 2-pixel moves: converged on the third
        send_result(pk(102, 50, 902, 600, 502, 300), pk(102, 50, 902, 600, 502, 300),
                    pk(102, 50, 502, 300, 902, 600), 1'b0, 1'b0);
        send_result(pk(104, 50, 904, 600, 504, 300), pk(104, 50, 904, 600, 504, 300),
                    pk(104, 50, 504, 300, 904, 600), 1'b0, 1'b0);
        send_result(pk(106, 50, 906, 600, 506, 300), pk(106, 50, 906, 600, 506, 300),
                    pk(106, 50, 506, 300, 906, 600), 1'b1, 1'b0);
        send_result(pk(108, 50, 908, 600, 508, 300), pk(108, 50, 908, 600, 508, 300),
                    pk(108, 50, 508, 300, 908, 600), 1'b1, 1'b0);
        // 10-pixel move clears convergence
        send_result(pk(118, 50, 908, 600, 508, 300), pk(118, 50, 908, 600, 508, 300),
                    pk(118, 50, 508, 300, 908, 600), 1'b0, 1'b0);
        // A x out of range: A kept, move 0; B/C move 2 -> still
        send_result(pk(2047, 0, 910, 600, 506, 300), pk(118, 50, 910, 600, 506, 300),
                    pk(118, 50, 506, 300, 910, 600), 1'b0, 1'b0);
        // C y out of range; A/B tie on x
        send_result(pk(500, 10, 500, 20, 500, 1023), pk(500, 10, 500, 20, 506, 300),
                    pk(500, 10, 500, 20, 506, 300), 1'b0, 1'b0);
        // C x == H_ACTIVE kept; three-way tie keeps A,B,C order
        send_result(pk(506, 5, 506, 6, 1280, 0), pk(506, 5, 506, 6, 506, 300),
                    pk(506, 5, 506, 6, 506, 300), 1'b0, 1'b0);
        // Largest in-range point, reverse order
        send_result(pk(1279, 719, 506, 6, 0, 0), pk(1279, 719, 506, 6, 0, 0),
                    pk(0, 0, 506, 6, 1279, 719), 1'b0, 1'b0);
        // Move of exactly CONV_THRESH is still (count 1)
        send_result(pk(1279, 715, 506, 6, 0, 0), pk(1279, 715, 506, 6, 0, 0),
                    pk(0, 0, 506, 6, 1279, 715), 1'b0, 1'b0);

        // Timeout: tabulate cycle T, timeout visible at negedge T+17
        do_frame();
        @(posedge clk_in); #1 frame_done_in = 1'b1;
        @(negedge clk_in); check("frame_dropped_in_wait", 64'(tabulate_out), 64'd0);
        @(posedge clk_in); #1 frame_done_in = 1'b0;
        n = 2;
        while (n < 40) begin
            @(negedge clk_in);
            n++;
            if (timeout_out) break;
        end
        check("timeout_latency", 64'(n), 64'd17);
        check("timeout_state_idle", 64'(state_out), 64'(ST_IDLE));
        check("timeout_centroids", 64'(cent_now), 64'(pk(1279, 715, 506, 6, 0, 0)));
        // Result while idle is ignored
        @(posedge clk_in); #1;
        {km_a_x_in, km_a_y_in, km_b_x_in, km_b_y_in, km_c_x_in, km_c_y_in} = pk(1, 1, 2, 2, 3, 3);
        km_valid_in = 1'b1;
        @(posedge clk_in); #1 km_valid_in = 1'b0;
        @(negedge clk_in); check("idle_result_ignored", 64'(cent_now), 64'(pk(1279, 715, 506, 6, 0, 0)));
        @(negedge clk_in); check("idle_no_update", 64'(update_valid_out), 64'd0);
        // Still counter survives the timeout: counts 2 then 3
        send_result(pk(1279, 717, 506, 6, 0, 0), pk(1279, 717, 506, 6, 0, 0),
                    pk(0, 0, 506, 6, 1279, 717), 1'b0, 1'b1);
        check("state_idle_after_same_cycle_frame", 64'(state_out), 64'(ST_IDLE));
        send_result(pk(1279, 719, 506, 6, 0, 0), pk(1279, 719, 506, 6, 0, 0),
                    pk(0, 0, 506, 6, 1279, 719), 1'b1, 1'b0);
        check("timeout_sticky", 64'(timeout_out), 64'd1);

        // Reset mid-wait, then a late result
        do_frame();
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b0;
        #1;
        check("async_rst_centroids", 64'(cent_now), 64'(pk(320, 360, 640, 360, 960, 360)));
        check("async_rst_keys", 64'(key_now), 64'(pk(320, 360, 640, 360, 960, 360)));
        check("async_rst_flags", 64'({converged_out, timeout_out, update_valid_out}), 64'd0);
        check("async_rst_state", 64'(state_out), 64'(ST_IDLE));
        @(posedge clk_in); #1 rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        {km_a_x_in, km_a_y_in, km_b_x_in, km_b_y_in, km_c_x_in, km_c_y_in} = pk(100, 50, 900, 600, 500, 300);
        km_valid_in = 1'b1;
        @(posedge clk_in); #1 km_valid_in = 1'b0;
        @(negedge clk_in); check("post_rst_centroids", 64'(cent_now), 64'(pk(320, 360, 640, 360, 960, 360)));
        @(negedge clk_in); check("post_rst_no_update", 64'(update_valid_out), 64'd0);
        repeat (3) @(negedge clk_in);
        check("post_rst_keys", 64'(key_now), 64'(pk(320, 360, 640, 360, 960, 360)));
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
